// File: rtl/egress_port.sv
// Egress port: destination check, DEPTH-entry output FIFO, valid/ready drain and host statistics.
// Optional EGRESS_LATENCY_EN adds per-word delivery latency and its running maximum.
module egress_port #(
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned META_WIDTH = 32,
   parameter int unsigned PORT_ID    = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [META_WIDTH-1:0] egress_in,
   input  logic                  egress_in_en,
   output logic [META_WIDTH-1:0] egress_out,
   output logic                  egress_out_valid,
   input  logic                  egress_out_ready,
   output logic                  is_full,
   output logic [31:0]           rx_cnt,
   output logic [15:0]           drop_cnt,
   output logic [15:0]           misroute_cnt,
   output logic [15:0]           latency_out,
   output logic [15:0]           latency_max
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [META_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW:0]           occ;
   logic [AW:0]           occ_nxt;
   logic [META_WIDTH-1:0] head;
   logic                  dest_ok;
   logic                  wr_en;
   logic                  drop_en;
   logic                  misroute_en;
   logic                  pop;

   // Accept decision: misroute first, then full (registered, pre-edge occupancy)
   always_comb begin
      dest_ok     = (egress_in[29:28] == 2'(PORT_ID));
      misroute_en = egress_in_en && !dest_ok;
      drop_en     = egress_in_en && dest_ok && is_full;
      wr_en       = egress_in_en && dest_ok && !is_full;
      pop         = (occ != '0) && (!egress_out_valid || egress_out_ready);
      head        = mem[rd_ptr];
      occ_nxt     = occ + (AW+1)'(wr_en) - (AW+1)'(pop);
   end

   always_ff @(posedge clk) begin
      if (wr_en && !reset) mem[wr_ptr] <= egress_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         occ              <= '0;
         is_full          <= 1'b0;
         egress_out       <= '0;
         egress_out_valid <= 1'b0;
         rx_cnt           <= '0;
         drop_cnt         <= '0;
         misroute_cnt     <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
            rx_cnt <= rx_cnt + 32'd1;
         end
         // Output register refills from the head whenever it is empty or draining
         if (pop) begin
            egress_out       <= head;
            egress_out_valid <= 1'b1;
            rd_ptr           <= rd_ptr + AW'(1);
         end else if (egress_out_valid && egress_out_ready) begin
            egress_out_valid <= 1'b0;
         end
         occ     <= occ_nxt;
         is_full <= (occ_nxt == (AW+1)'(DEPTH));
         if (drop_en && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
         if (misroute_en && misroute_cnt != 16'hFFFF)
            misroute_cnt <= misroute_cnt + 16'd1;
      end
   end

`ifdef EGRESS_LATENCY_EN
   logic [15:0] cyc_cnt;

   // Latency is stamped when a word enters the output register
   always_ff @(posedge clk) begin
      if (reset) begin
         cyc_cnt     <= '0;
         latency_out <= '0;
         latency_max <= '0;
      end else begin
         cyc_cnt <= cyc_cnt + 16'd1;
         if (pop)
            latency_out <= cyc_cnt - head[15:0];
         if (egress_out_valid && egress_out_ready && latency_out > latency_max)
            latency_max <= latency_out;
      end
   end
`else
   assign latency_out = '0;
   assign latency_max = '0;
`endif

endmodule

// File: tb/tb_egress_port.sv
// Directed bench for egress_port (DEPTH=4, PORT_ID=0) with a scoreboard of expected output words.
module tb_egress_port;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] egress_in;
   logic        egress_in_en;
   logic [31:0] egress_out;
   logic        egress_out_valid;
   logic        egress_out_ready;
   logic        is_full;
   logic [31:0] rx_cnt;
   logic [15:0] drop_cnt;
   logic [15:0] misroute_cnt;
   logic [15:0] latency_out;
   logic [15:0] latency_max;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic [31:0] sb_q[$];
   logic        stalled = 1'b0;
   logic [31:0] held   = '0;
   logic        tog    = 1'b0;

   egress_port #(.DEPTH(4), .META_WIDTH(32), .PORT_ID(0)) dut (
      .clk(clk), .reset(reset),
      .egress_in(egress_in), .egress_in_en(egress_in_en),
      .egress_out(egress_out), .egress_out_valid(egress_out_valid),
      .egress_out_ready(egress_out_ready), .is_full(is_full),
      .rx_cnt(rx_cnt), .drop_cnt(drop_cnt), .misroute_cnt(misroute_cnt),
      .latency_out(latency_out), .latency_max(latency_max)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One cycle: drive at negedge, check stall stability and transfers, advance to next negedge
   task automatic step(input logic en, input logic [31:0] d, input logic rdy);
      logic [31:0] exp_w;
      egress_in_en     = en;
      egress_in        = d;
      egress_out_ready = rdy;
      if (!reset) begin
         if (stalled) begin
            chk("stall_valid", 32'(egress_out_valid), 32'd1);
            chk("stall_data", egress_out, held);
         end
         if (egress_out_valid && rdy) begin
            chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
               exp_w = sb_q.pop_front();
               chk("sb_word", egress_out, exp_w);
            end
         end
         stalled = egress_out_valid && !rdy;
         held    = egress_out;
      end else begin
         stalled = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1'b1, 32'h0000_5A5A, 1'b0);
      reset = 1'b0;
      sb_q.delete();
   endtask

   task automatic drain(input logic toggle);
      for (int k = 0; k < 200 && sb_q.size() != 0; k++) begin
         step(1'b0, 32'h0, toggle ? tog : 1'b1);
         tog = ~tog;
      end
      chk("drain_done", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      reset = 1'b1; egress_in = '0; egress_in_en = 1'b0; egress_out_ready = 1'b0;
      @(negedge clk);
      do_reset();
      chk("rst_valid", 32'(egress_out_valid), 32'd0);
      chk("rst_out", egress_out, 32'd0);
      chk("rst_full", 32'(is_full), 32'd0);
      chk("rst_rx", rx_cnt, 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      chk("rst_mis", 32'(misroute_cnt), 32'd0);
      chk("rst_lat", 32'(latency_out), 32'd0);
      chk("rst_latmax", 32'(latency_max), 32'd0);
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      chk("rst_input_ignored", 32'(egress_out_valid), 32'd0);

      // Single word: valid two cycles after acceptance, for one cycle
      do_reset();
      sb_q.push_back(32'h0000_1234);
      step(1'b1, 32'h0000_1234, 1'b1);
      chk("lat_n1_valid", 32'(egress_out_valid), 32'd0);
      step(1'b0, 32'h0, 1'b1);
      chk("lat_n2_valid", 32'(egress_out_valid), 32'd1);
      chk("lat_n2_data", egress_out, 32'h0000_1234);
      chk("single_rx", rx_cnt, 32'd1);
      step(1'b0, 32'h0, 1'b1);
      chk("single_gone", 32'(egress_out_valid), 32'd0);

      // Misrouted word never reaches the output
      do_reset();
      step(1'b1, 32'h2000_0000, 1'b1);
      for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b1);
      chk("mis_valid", 32'(egress_out_valid), 32'd0);
      chk("mis_cnt", 32'(misroute_cnt), 32'd1);
      chk("mis_rx", rx_cnt, 32'd0);

      // Fill: 4 in memory + 1 in output register, 2 dropped
      do_reset();
      for (int i = 0; i < 7; i++) begin
         if (i < 5) sb_q.push_back(32'h0000_0100 + 32'(i));
         step(1'b1, 32'h0000_0100 + 32'(i), 1'b0);
      end
      chk("fill_full", 32'(is_full), 32'd1);
      chk("fill_rx", rx_cnt, 32'd5);
      chk("fill_drop", 32'(drop_cnt), 32'd2);
      chk("fill_head", egress_out, 32'h0000_0100);
      step(1'b1, 32'h1000_0000, 1'b0);
      chk("prio_mis", 32'(misroute_cnt), 32'd1);
      chk("prio_drop", 32'(drop_cnt), 32'd2);
      step(1'b1, 32'h0000_0EEE, 1'b1);
      chk("wrpop_drop", 32'(drop_cnt), 32'd3);
      chk("wrpop_notfull", 32'(is_full), 32'd0);
      chk("wrpop_rx", rx_cnt, 32'd5);
      drain(1'b0);

      // Burst with ready toggling every cycle
      do_reset();
      tog = 1'b1;
      for (int i = 0; i < 20; i++) begin
         sb_q.push_back(32'h0000_2000 + 32'(i));
         step(1'b1, 32'h0000_2000 + 32'(i), tog);
         tog = ~tog;
         step(1'b0, 32'h0, tog);
         tog = ~tog;
      end
      drain(1'b1);
      chk("burst_rx", rx_cnt, 32'd20);
      chk("burst_drop", 32'(drop_cnt), 32'd0);

      // Reset mid-burst flushes everything
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 32'h0000_3000 + 32'(i), 1'b0);
      chk("pre_rst_rx", rx_cnt, 32'd3);
      do_reset();
      chk("mid_rst_valid", 32'(egress_out_valid), 32'd0);
      chk("mid_rst_rx", rx_cnt, 32'd0);
      chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
      chk("mid_rst_mis", 32'(misroute_cnt), 32'd0);
      chk("mid_rst_full", 32'(is_full), 32'd0);
      for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b1);
      chk("mid_rst_empty", 32'(egress_out_valid), 32'd0);

`ifdef EGRESS_LATENCY_EN
      // Counter 100 at load, timestamp 40
      do_reset();
      for (int k = 0; k < 99; k++) step(1'b0, 32'h0, 1'b1);
      sb_q.push_back(32'h0000_0028);
      step(1'b1, 32'h0000_0028, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      chk("lat_out60", 32'(latency_out), 32'd60);
      step(1'b0, 32'h0, 1'b1);
      chk("lat_max60", 32'(latency_max), 32'd60);
      // Counter 0x10 at load, timestamp 0xFFF0 wraps
      do_reset();
      for (int k = 0; k < 15; k++) step(1'b0, 32'h0, 1'b1);
      sb_q.push_back(32'h0000_FFF0);
      step(1'b1, 32'h0000_FFF0, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      chk("lat_wrap", 32'(latency_out), 32'h0000_0020);
      step(1'b0, 32'h0, 1'b1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
